layer_scheduler: RTL and testbench

Sequencer that runs a complete forward pass across the four neural units. For each layer it streams the 16 per-layer weights out of the weight RAM, steers each weight to the correct unit and input slot, triggers the multiply-accumulate, and waits for all four units to finish. It then tells the data register bank to latch the layer outputs. It sits between the network start/done handshake, the weight RAM read port, the four neural units and the data register bank, and replaces ad-hoc read-driver and mux sequencing with one owned FSM.

---
 rtl/nn_pkg.sv | 25 ++
 rtl/rd_pipe.sv | 41 ++++
 rtl/layer_scheduler.sv | 173 +++++++++++++++++
 tb/tb_layer_scheduler.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the layer scheduler: FSM state encoding,
// per-layer weight geometry and the unit strobe helper.
package nn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_SUM,
    ST_WAIT_DONE,
    ST_NEXT,
    ST_FIN
  } state_t;

  localparam int WEIGHTS_PER_LAYER = 16;
  localparam int NUM_UNITS         = 4;
  localparam int WEIGHT_W          = 8;

  // One-hot write strobe for the unit addressed by u.
  function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [1:0] u);
    unit_onehot    = '0;
    unit_onehot[u] = 1'b1;
  endfunction

endpackage

// File: rtl/rd_pipe.sv
// Shift register that tracks each outstanding weight read (valid, unit, slot)
// for exactly DEPTH cycles so it lines up with the RAM read data.
module rd_pipe #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [1:0] in_u,
  input  logic [1:0] in_i,
  output logic       out_valid,
  output logic [1:0] out_u,
  output logic [1:0] out_i
);

  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0][1:0] u_q;
  logic [DEPTH-1:0][1:0] i_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      u_q     <= '0;
      i_q     <= '0;
    end else begin
      valid_q[0] <= in_valid;
      u_q[0]     <= in_u;
      i_q[0]     <= in_i;
      for (int s = 1; s < DEPTH; s++) begin
        valid_q[s] <= valid_q[s-1];
        u_q[s]     <= u_q[s-1];
        i_q[s]     <= i_q[s-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_u     = u_q[DEPTH-1];
  assign out_i     = i_q[DEPTH-1];

endmodule

// File: rtl/layer_scheduler.sv
// Forward-pass sequencer: streams 16 weights per layer to the four units,
// triggers accumulation, waits for completion and latches the layer outputs.
// Optional busy-cycle counter port enabled by LAYER_SCHED_PERF_EN.
module layer_scheduler
  import nn_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0,
  parameter int RAM_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [ADDR_W-1:0]    ram_addr,
  input  logic [WEIGHT_W-1:0]  ram_data,
  output logic [WEIGHT_W-1:0]  weight_out,
  output logic [NUM_UNITS-1:0] weight_we,
  output logic [1:0]           weight_idx,
  output logic                 sum_trigger,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 layer_sel,
  output logic [1:0]           layer,
  output logic                 bank_latch,
  output logic                 busy,
  output logic                 done
`ifdef LAYER_SCHED_PERF_EN
  ,
  output logic [15:0]          cycle_count
`endif
);

  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [3:0]        LAST_K     = 4'(WEIGHTS_PER_LAYER - 1);
  localparam logic [1:0]        LAST_DRAIN = 2'(RAM_LAT - 1);
  localparam logic [1:0]        LAST_LAYER = 2'(NUM_LAYERS - 1);

  state_t                state_reg, state_next;
  logic [3:0]            k_reg, k_next;
  logic [1:0]            drain_reg, drain_next;
  logic [1:0]            layer_reg, layer_next;
  logic                  wait_first_reg, wait_first_next;

  logic [WEIGHT_W-1:0]   weight_out_reg;
  logic [NUM_UNITS-1:0]  weight_we_reg;
  logic [1:0]            weight_idx_reg;

  logic                  pipe_valid;
  logic [1:0]            pipe_u;
  logic [1:0]            pipe_i;

  // Issue counter k doubles as {unit, slot}, so the address is a plain concat.
  assign ram_addr = BASE + ADDR_W'({layer_reg, k_reg});

  rd_pipe #(
    .DEPTH (RAM_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (state_reg == ST_FETCH),
    .in_u      (k_reg[3:2]),
    .in_i      (k_reg[1:0]),
    .out_valid (pipe_valid),
    .out_u     (pipe_u),
    .out_i     (pipe_i)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      k_reg          <= '0;
      drain_reg      <= '0;
      layer_reg      <= '0;
      wait_first_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      k_reg          <= k_next;
      drain_reg      <= drain_next;
      layer_reg      <= layer_next;
      wait_first_reg <= wait_first_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    k_next          = k_reg;
    drain_next      = drain_reg;
    layer_next      = layer_reg;
    wait_first_next = wait_first_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          layer_next = '0;
          k_next     = '0;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        k_next = k_reg + 4'd1;
        if (k_reg == LAST_K) begin
          drain_next = '0;
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_reg == LAST_DRAIN) state_next = ST_SUM;
        else                         drain_next = drain_reg + 2'd1;
      end
      ST_SUM: begin
        wait_first_next = 1'b1;
        state_next      = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // Units clear their flags on sum_trigger one cycle late; skip that cycle.
        wait_first_next = 1'b0;
        if (!wait_first_reg && (&unit_done)) state_next = ST_NEXT;
      end
      ST_NEXT: begin
        if (layer_reg == LAST_LAYER) begin
          state_next = ST_FIN;
        end else begin
          layer_next = layer_reg + 2'd1;
          k_next     = '0;
          state_next = ST_FETCH;
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      weight_out_reg <= '0;
      weight_we_reg  <= '0;
      weight_idx_reg <= '0;
    end else if (pipe_valid) begin
      weight_out_reg <= ram_data;
      weight_we_reg  <= unit_onehot(pipe_u);
      weight_idx_reg <= pipe_i;
    end else begin
      weight_we_reg  <= '0;
    end
  end

  assign weight_out  = weight_out_reg;
  assign weight_we   = weight_we_reg;
  assign weight_idx  = weight_idx_reg;
  assign sum_trigger = (state_reg == ST_SUM);
  assign bank_latch  = (state_reg == ST_NEXT);
  assign done        = (state_reg == ST_FIN);
  assign busy        = (state_reg != ST_IDLE);
  assign layer       = layer_reg;
  assign layer_sel   = (layer_reg != 2'd0);

`ifdef LAYER_SCHED_PERF_EN
  logic [15:0] cycle_count_reg;

  // Counts FETCH through NEXT; FIN is excluded so the value is final when done pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count_reg <= '0;
    end else if (state_reg == ST_IDLE) begin
      if (start) cycle_count_reg <= '0;
    end else if (state_reg != ST_FIN && cycle_count_reg != 16'hFFFF) begin
      cycle_count_reg <= cycle_count_reg + 16'd1;
    end
  end

  assign cycle_count = cycle_count_reg;
`endif

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler: a single-layer instance (RAM_LAT=1) and a
// three-layer instance (BASE_ADDR=100, RAM_LAT=3) with RAM and unit models.
module tb_layer_scheduler;

  localparam int LOG = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic [9:0] addr_a, addr_b;
  logic [7:0] rdata_a = '0, rdata_b = '0, b1 = '0, b2 = '0;
  logic [7:0] wout_a, wout_b;
  logic [3:0] we_a, we_b, ud_a, ud_b;
  logic [1:0] idx_a, idx_b, layer_a, layer_b;
  logic sum_a, sum_b, lsel_a, lsel_b, latch_a, latch_b, busy_a, busy_b, done_a, done_b;
`ifdef LAYER_SCHED_PERF_EN
  logic [15:0] cc_a, cc_b;
`endif

  layer_scheduler #(.NUM_LAYERS(1), .ADDR_W(10), .BASE_ADDR(0), .RAM_LAT(1)) dut_a (
    .clk(clk), .reset(rst_n), .start(start_a), .ram_addr(addr_a), .ram_data(rdata_a),
    .weight_out(wout_a), .weight_we(we_a), .weight_idx(idx_a), .sum_trigger(sum_a),
    .unit_done(ud_a), .layer_sel(lsel_a), .layer(layer_a), .bank_latch(latch_a),
    .busy(busy_a), .done(done_a)
`ifdef LAYER_SCHED_PERF_EN
    , .cycle_count(cc_a)
`endif
  );

  layer_scheduler #(.NUM_LAYERS(3), .ADDR_W(10), .BASE_ADDR(100), .RAM_LAT(3)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .ram_addr(addr_b), .ram_data(rdata_b),
    .weight_out(wout_b), .weight_we(we_b), .weight_idx(idx_b), .sum_trigger(sum_b),
    .unit_done(ud_b), .layer_sel(lsel_b), .layer(layer_b), .bank_latch(latch_b),
    .busy(busy_b), .done(done_b)
`ifdef LAYER_SCHED_PERF_EN
    , .cycle_count(cc_b)
`endif
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int since_a = 0, since_b = 0;
  int dly_a[4] = '{1, 1, 1, 1};
  int dly_b[4] = '{1, 1, 1, 1};
  bit stale_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM returns address[7:0] with the configured latency.
  always @(posedge clk) begin
    rdata_a <= addr_a[7:0];
    b1      <= addr_b[7:0];
    b2      <= b1;
    rdata_b <= b2;
  end

  // Unit model: unit u reports done dly[u] cycles after the SUM cycle.
  always @(posedge clk) begin
    if (sum_a) since_a <= 1;
    else if (since_a != 0 && since_a < 1000) since_a <= since_a + 1;
    if (sum_b) since_b <= 1;
    else if (since_b != 0 && since_b < 1000) since_b <= since_b + 1;
  end

  always_comb begin
    ud_a = 4'h0;
    for (int u = 0; u < 4; u++)
      if (since_a != 0 && since_a >= dly_a[u]) ud_a[u] = 1'b1;
  end

  always_comb begin
    ud_b = 4'h0;
    if (stale_b && since_b == 1) ud_b = 4'hF;
    else
      for (int u = 0; u < 4; u++)
        if (since_b != 0 && since_b >= dly_b[u]) ud_b[u] = 1'b1;
  end

  logic [9:0] addr_a_l[LOG], addr_b_l[LOG];
  logic [7:0] wout_a_l[LOG], wout_b_l[LOG];
  logic [3:0] we_a_l[LOG], we_b_l[LOG];
  logic [1:0] idx_a_l[LOG], idx_b_l[LOG], layer_b_l[LOG];
  logic       sum_a_l[LOG], sum_b_l[LOG], latch_a_l[LOG], latch_b_l[LOG];
  logic       done_a_l[LOG], done_b_l[LOG], busy_a_l[LOG], lsel_b_l[LOG];

  always @(negedge clk) begin
    if (cyc < LOG) begin
      addr_a_l[cyc] <= addr_a;  addr_b_l[cyc] <= addr_b;
      wout_a_l[cyc] <= wout_a;  wout_b_l[cyc] <= wout_b;
      we_a_l[cyc]   <= we_a;    we_b_l[cyc]   <= we_b;
      idx_a_l[cyc]  <= idx_a;   idx_b_l[cyc]  <= idx_b;
      sum_a_l[cyc]  <= sum_a;   sum_b_l[cyc]  <= sum_b;
      latch_a_l[cyc] <= latch_a; latch_b_l[cyc] <= latch_b;
      done_a_l[cyc] <= done_a;  done_b_l[cyc] <= done_b;
      busy_a_l[cyc] <= busy_a;  lsel_b_l[cyc] <= lsel_b;
      layer_b_l[cyc] <= layer_b;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (addr_a !== 10'd0) begin
      errors++; $display("FAIL reset_addr_a got %0d want 0", addr_a);
    end
    checks++;
    if (addr_b !== 10'd100) begin
      errors++; $display("FAIL reset_addr_b got %0d want 100", addr_b);
    end
    checks++;
    if ({busy_a, done_a, sum_a, latch_a, lsel_a, layer_a, we_a, idx_a, wout_a} !== 21'd0) begin
      errors++; $display("FAIL reset_outs_a got %h want 0",
                         {busy_a, done_a, sum_a, latch_a, lsel_a, layer_a, we_a, idx_a, wout_a});
    end
    checks++;
    if ({busy_b, done_b, sum_b, latch_b, lsel_b, layer_b, we_b, idx_b, wout_b} !== 21'd0) begin
      errors++; $display("FAIL reset_outs_b got %h want 0",
                         {busy_b, done_b, sum_b, latch_b, lsel_b, layer_b, we_b, idx_b, wout_b});
    end
`ifdef LAYER_SCHED_PERF_EN
    checks++;
    if (cc_b !== 16'd0) begin
      errors++; $display("FAIL reset_cycle_count got %0d want 0", cc_b);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_layer();
    int t0, tdone, nbits, nsum, nlatch, ndone;
    logic [3:0] one4 = 4'b0001;
    logic [13:0] exp_s;
    dly_a = '{1, 1, 1, 1};
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0; t0 = cyc;
    tdone = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin tdone = cyc; break; end
    end
    repeat (6) @(negedge clk);
    checks++;
    if (tdone - t0 !== 21) begin
      errors++; $display("FAIL single_done_latency got %0d want 21", tdone - t0);
    end
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (addr_a_l[t0+j] !== 10'(j)) begin
        errors++; $display("FAIL single_addr[%0d] got %0d want %0d", j, addr_a_l[t0+j], j);
      end
      exp_s = {one4 << (j / 4), 2'(j % 4), 8'(j)};
      checks++;
      if ({we_a_l[t0+j+2], idx_a_l[t0+j+2], wout_a_l[t0+j+2]} !== exp_s) begin
        errors++; $display("FAIL single_strobe[%0d] got %h want %h", j,
                           {we_a_l[t0+j+2], idx_a_l[t0+j+2], wout_a_l[t0+j+2]}, exp_s);
      end
    end
    nbits = 0; nsum = 0; nlatch = 0; ndone = 0;
    for (int c = t0; c < t0 + 25; c++) begin
      nbits  += $countones(we_a_l[c]);
      nsum   += int'(sum_a_l[c]);
      nlatch += int'(latch_a_l[c]);
      ndone  += int'(done_a_l[c]);
    end
    checks++;
    if (nbits !== 16) begin errors++; $display("FAIL single_strobe_bits got %0d want 16", nbits); end
    checks++;
    if ({sum_a_l[t0+17], latch_a_l[t0+20], done_a_l[t0+21]} !== 3'b111 || nsum !== 1 || nlatch !== 1 || ndone !== 1) begin
      errors++; $display("FAIL single_pulses got sum=%0d latch=%0d done=%0d want 1 1 1 at 17/20/21",
                         nsum, nlatch, ndone);
    end
    checks++;
    if ({busy_a_l[t0], busy_a_l[t0+22]} !== 2'b10) begin
      errors++; $display("FAIL single_busy got %b want 10", {busy_a_l[t0], busy_a_l[t0+22]});
    end
`ifdef LAYER_SCHED_PERF_EN
    checks++;
    if (cc_a !== 16'd21) begin errors++; $display("FAIL single_cycle_count got %0d want 21", cc_a); end
`endif
  endtask

  task automatic test_three_layers();
    int t0, tdone, nbits, nlatch, ndone, bad;
    logic [3:0] one4 = 4'b0001;
    logic [13:0] exp_s;
    int tc;
    dly_b = '{5, 9, 2, 12}; stale_b = 1'b1;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0; t0 = cyc;
    tdone = -1;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (done_b === 1'b1) begin tdone = cyc; break; end
    end
    repeat (8) @(negedge clk);
    checks++;
    if (tdone - t0 !== 99) begin
      errors++; $display("FAIL three_done_latency got %0d want 99", tdone - t0);
    end
    checks++;
    if (addr_b_l[t0] !== 10'd100) begin
      errors++; $display("FAIL three_first_addr got %0d want 100", addr_b_l[t0]);
    end
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (addr_b_l[t0+66+j] !== 10'(132 + j)) begin
        errors++; $display("FAIL three_l2_addr[%0d] got %0d want %0d", j, addr_b_l[t0+66+j], 132 + j);
      end
    end
    for (int l = 0; l < 3; l++) begin
      for (int j = 0; j < 16; j++) begin
        tc = t0 + l * 33 + j + 4;
        exp_s = {one4 << (j / 4), 2'(j % 4), 8'(100 + l * 16 + j)};
        checks++;
        if ({we_b_l[tc], idx_b_l[tc], wout_b_l[tc]} !== exp_s) begin
          errors++; $display("FAIL three_strobe[l%0d,%0d] got %h want %h", l, j,
                             {we_b_l[tc], idx_b_l[tc], wout_b_l[tc]}, exp_s);
        end
      end
    end
    checks++;
    if ({sum_b_l[t0+18], sum_b_l[t0+19]} !== 2'b01) begin
      errors++; $display("FAIL three_drain_sum got %b want 01", {sum_b_l[t0+18], sum_b_l[t0+19]});
    end
    checks++;
    if ({latch_b_l[t0+21], latch_b_l[t0+31], latch_b_l[t0+32]} !== 3'b001) begin
      errors++; $display("FAIL three_wait_exit got %b want 001",
                         {latch_b_l[t0+21], latch_b_l[t0+31], latch_b_l[t0+32]});
    end
    nbits = 0; nlatch = 0; ndone = 0; bad = 0;
    for (int c = t0; c < t0 + 104; c++) begin
      nbits  += $countones(we_b_l[c]);
      nlatch += int'(latch_b_l[c]);
      ndone  += int'(done_b_l[c]);
    end
    for (int c = 0; c < 99; c++)
      if (lsel_b_l[t0+c] !== ((c >= 33) ? 1'b1 : 1'b0)) bad++;
    checks++;
    if (nbits !== 48) begin errors++; $display("FAIL three_strobe_bits got %0d want 48", nbits); end
    checks++;
    if (nlatch !== 3 || ndone !== 1) begin
      errors++; $display("FAIL three_pulse_count got latch=%0d done=%0d want 3 1", nlatch, ndone);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL three_layer_sel got %0d bad cycles want 0", bad); end
    checks++;
    if ({layer_b_l[t0+32], layer_b_l[t0+33], layer_b_l[t0+65], layer_b_l[t0+66]} !== 8'b00_01_01_10) begin
      errors++; $display("FAIL three_layer_idx got %b want 00010110",
                         {layer_b_l[t0+32], layer_b_l[t0+33], layer_b_l[t0+65], layer_b_l[t0+66]});
    end
  endtask

  task automatic test_reset_mid_pass();
    int t0, t1, tdone, nq, ndone;
    dly_b = '{5, 9, 2, 12}; stale_b = 1'b1;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0; t0 = cyc;
    repeat (38) @(negedge clk);
    checks++;
    if ({busy_b, layer_b} !== 3'b101) begin
      errors++; $display("FAIL midreset_pre_state got %b want 101", {busy_b, layer_b});
    end
    @(posedge clk); #2; rst_n = 1'b0; #1;
    checks++;
    if ({busy_b, done_b, sum_b, latch_b, lsel_b, layer_b, we_b, idx_b, wout_b} !== 21'd0) begin
      errors++; $display("FAIL midreset_async_outs got %h want 0",
                         {busy_b, done_b, sum_b, latch_b, lsel_b, layer_b, we_b, idx_b, wout_b});
    end
    checks++;
    if (addr_b !== 10'd100) begin
      errors++; $display("FAIL midreset_addr got %0d want 100", addr_b);
    end
    nq = 0;
    repeat (3) begin @(negedge clk); if (done_b !== 1'b0 || busy_b !== 1'b0) nq++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done_b !== 1'b0 || busy_b !== 1'b0 || we_b !== 4'd0) nq++; end
    checks++;
    if (nq !== 0) begin errors++; $display("FAIL midreset_quiet got %0d active cycles want 0", nq); end
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0; t1 = cyc;
    tdone = -1;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (done_b === 1'b1) begin tdone = cyc; break; end
    end
    repeat (6) @(negedge clk);
    checks++;
    if ({layer_b_l[t1], addr_b_l[t1]} !== {2'd0, 10'd100}) begin
      errors++; $display("FAIL midreset_restart got layer=%0d addr=%0d want 0 100", layer_b_l[t1], addr_b_l[t1]);
    end
    checks++;
    if ({we_b_l[t1], we_b_l[t1+1], we_b_l[t1+2], we_b_l[t1+3]} !== 16'd0) begin
      errors++; $display("FAIL midreset_flush got %h want 0",
                         {we_b_l[t1], we_b_l[t1+1], we_b_l[t1+2], we_b_l[t1+3]});
    end
    checks++;
    if ({we_b_l[t1+4], idx_b_l[t1+4], wout_b_l[t1+4]} !== {4'b0001, 2'd0, 8'd100}) begin
      errors++; $display("FAIL midreset_first_strobe got %h want %h",
                         {we_b_l[t1+4], idx_b_l[t1+4], wout_b_l[t1+4]}, {4'b0001, 2'd0, 8'd100});
    end
    ndone = 0;
    for (int c = t1; c < t1 + 104; c++) ndone += int'(done_b_l[c]);
    checks++;
    if (tdone - t1 !== 99 || ndone !== 1) begin
      errors++; $display("FAIL midreset_rerun got latency=%0d done=%0d want 99 1", tdone - t1, ndone);
    end
  endtask

  task automatic test_back_to_back();
    int t0, td1, td2;
    dly_a = '{1, 1, 1, 1};
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); t0 = cyc;
    td1 = -1; td2 = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin td1 = cyc; break; end
    end
    repeat (2) @(negedge clk);
    start_a = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin td2 = cyc; break; end
    end
    repeat (6) @(negedge clk);
    checks++;
    if (td1 - t0 !== 21) begin errors++; $display("FAIL b2b_first_done got %0d want 21", td1 - t0); end
    checks++;
    if ({busy_a_l[t0+21], busy_a_l[t0+22], busy_a_l[t0+23]} !== 3'b101) begin
      errors++; $display("FAIL b2b_idle_gap got %b want 101",
                         {busy_a_l[t0+21], busy_a_l[t0+22], busy_a_l[t0+23]});
    end
    checks++;
    if (addr_a_l[t0+23] !== 10'd0) begin
      errors++; $display("FAIL b2b_restart_addr got %0d want 0", addr_a_l[t0+23]);
    end
    checks++;
    if (td2 - t0 !== 44) begin errors++; $display("FAIL b2b_second_done got %0d want 44", td2 - t0); end
    checks++;
    if (busy_a_l[t0+47] !== 1'b0) begin
      errors++; $display("FAIL b2b_no_third_pass got %b want 0", busy_a_l[t0+47]);
    end
`ifdef LAYER_SCHED_PERF_EN
    checks++;
    if (cc_a !== 16'd21) begin errors++; $display("FAIL b2b_cycle_count got %0d want 21", cc_a); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_layer();
    test_three_layers();
    test_reset_mid_pass();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
